// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-side bus for the arbiter.
// slave is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_out,
        output if_ack, if_rdata,
        output d_ack, d_rdata,
        output mem_addr, mem_rd, mem_wr, mem_in,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_out,
        input  if_ack, if_rdata,
        input  d_ack, d_rdata,
        input  mem_addr, mem_rd, mem_wr, mem_in,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data arbiter for the shared unified memory.
// Sequences setup, strobe and release phases with registered strobes.
module mem_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } state_t;

    state_t state, state_nx;

    // gnt_q doubles as last_grant: 1 = data port, 0 = fetch port
    logic              gnt_q, gnt_nx;
    logic              we_q, we_nx;
    logic              pick_d;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] win_q, win_nx;
    logic              rd_q, rd_nx;
    logic              wr_q, wr_nx;
    logic              if_ack_q, if_ack_nx;
    logic              d_ack_q, d_ack_nx;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_nx;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, grant and next values of all registered outputs
    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt_q;
        we_nx       = we_q;
        addr_nx     = addr_q;
        win_nx      = win_q;
        rd_nx       = 1'b0;
        wr_nx       = 1'b0;
        if_ack_nx   = 1'b0;
        d_ack_nx    = 1'b0;
        if_rdata_nx = if_rdata_q;
        d_rdata_nx  = d_rdata_q;
        pick_d      = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie the port not served last wins
                    pick_d   = bus.d_req &&
                               (!bus.if_req || !gnt_q);
                    gnt_nx   = pick_d;
                    state_nx = SETUP;
                    if (pick_d) begin
                        we_nx   = bus.d_we;
                        addr_nx = bus.d_addr;
                        win_nx  = bus.d_wdata;
                    end else begin
                        we_nx   = 1'b0;
                        addr_nx = bus.if_addr;
                    end
                end
            end
            SETUP: begin
                state_nx = STROBE;
                rd_nx    = !we_q;
                wr_nx    = we_q;
            end
            STROBE: begin
                state_nx = DONE;
                if (!we_q) begin
                    if (gnt_q) begin
                        d_rdata_nx = bus.mem_out;
                    end else begin
                        if_rdata_nx = bus.mem_out;
                    end
                end
                d_ack_nx  = gnt_q;
                if_ack_nx = !gnt_q;
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latched operands, strobes, acks and read-data holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            win_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            gnt_q      <= gnt_nx;
            we_q       <= we_nx;
            addr_q     <= addr_nx;
            win_q      <= win_nx;
            rd_q       <= rd_nx;
            wr_q       <= wr_nx;
            if_ack_q   <= if_ack_nx;
            d_ack_q    <= d_ack_nx;
            if_rdata_q <= if_rdata_nx;
            d_rdata_q  <= d_rdata_nx;
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_in   = win_q;
    assign bus.mem_rd   = rd_q;
    assign bus.mem_wr   = wr_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level model.
// Includes a behavioural 32x16 memory that writes on the wr rising level.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        if (i == 21) return 16'hF400;
        if (i == 1) return 16'h0001;
        return 16'(i * 16'h0101) ^ 16'h5A00;
    endfunction

    // Memory block: preload, then write on every wr rising level
    logic [15:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = init_word(i);
        forever begin
            @(posedge bus.mem_wr);
            mem[bus.mem_addr] = bus.mem_in;
        end
    end
    assign bus.mem_out = mem[bus.mem_addr];

    int n_vec;
    int n_err;
    int cyc;

    // Transaction-level reference state
    logic [15:0] ref_mem [32];
    logic        have;
    int          m_gnt;
    int          m_ack_at;
    int          m_free;
    logic        m_pd;
    logic        m_last_d;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_exp;
    logic [15:0] m_ird;
    logic [15:0] m_drd;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h cyc=%0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic mdl_reset();
        have     = 1'b0;
        m_free   = 0;
        m_gnt    = 0;
        m_ack_at = -1;
        m_last_d = 1'b1;
        m_ird    = '0;
        m_drd    = '0;
    endtask

    task automatic rst_chk();
        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_d_ack", bus.d_ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_in", bus.mem_in, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
    endtask

    // One clock: model the edge, check outputs, return at negedge
    task automatic step();
        logic pd;
        logic busy_e;
        logic ack_e;
        @(posedge clk);
        cyc++;
        if (have && cyc == m_ack_at && !m_we) begin
            if (m_pd) m_drd = m_exp;
            else m_ird = m_exp;
        end
        if (cyc >= m_free && (bus.if_req || bus.d_req)) begin
            if (bus.if_req && bus.d_req) pd = !m_last_d;
            else pd = bus.d_req;
            have     = 1'b1;
            m_gnt    = cyc;
            m_ack_at = cyc + 2;
            m_free   = cyc + 4;
            m_pd     = pd;
            m_last_d = pd;
            m_we     = pd ? bus.d_we : 1'b0;
            m_addr   = pd ? bus.d_addr : bus.if_addr;
            m_wdata  = bus.d_wdata;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else m_exp = ref_mem[m_addr];
        end
        #1;
        busy_e = have && (cyc - m_gnt) < 3;
        ack_e  = have && cyc == m_ack_at;
        chk("if_ack", bus.if_ack, ack_e && !m_pd);
        chk("d_ack", bus.d_ack, ack_e && m_pd);
        chk("busy", bus.busy, busy_e);
        chk("mem_rd", bus.mem_rd,
            have && cyc == m_gnt + 1 && !m_we);
        chk("mem_wr", bus.mem_wr,
            have && cyc == m_gnt + 1 && m_we);
        chk("rd_wr_excl", bus.mem_rd & bus.mem_wr, 0);
        chk("if_rdata", bus.if_rdata, m_ird);
        chk("d_rdata", bus.d_rdata, m_drd);
        if (busy_e) chk("mem_addr", bus.mem_addr, m_addr);
        if (busy_e && m_we) chk("mem_in", bus.mem_in, m_wdata);
        @(negedge clk);
    endtask

    task automatic run_d(input logic we,
                         input logic [4:0] a,
                         input logic [15:0] w,
                         output int lat);
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_addr = a;
        bus.d_wdata = w;
        lat = 0;
        while (!bus.d_ack && lat < 12) begin
            step();
            lat++;
        end
        chk("d_timeout", bus.d_ack, 1);
        bus.d_req = 1'b0;
        step();
    endtask

    function automatic logic [4:0] raddr();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd31;
            default: return 5'($urandom);
        endcase
    endfunction

    int lat;
    int nrd;
    int ord[$];

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        mdl_reset();
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        rst = 1'b1;
        #12;
        rst_chk();
        @(negedge clk);
        rst = 1'b0;

        // Tie from reset: fetch first, then alternate
        bus.if_req = 1'b1;
        bus.if_addr = 5'd3;
        bus.d_req = 1'b1;
        bus.d_addr = 5'd7;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.if_ack) ord.push_back(0);
            if (bus.d_ack) ord.push_back(1);
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        chk("tie_count", ord.size(), 4);
        for (int i = 0; i < ord.size() && i < 4; i++)
            chk("tie_order", ord[i], i % 2);
        for (int i = 0; i < 4; i++) step();

        // Single fetch of word 21
        bus.if_req = 1'b1;
        bus.if_addr = 5'd21;
        lat = 0;
        nrd = 0;
        while (!bus.if_ack && lat < 12) begin
            step();
            lat++;
            if (bus.mem_rd) nrd++;
        end
        bus.if_req = 1'b0;
        chk("if_latency", lat, 3);
        chk("rd_pulses", nrd, 1);
        chk("if_f400", bus.if_rdata, 16'hF400);
        step();

        // Write then read address 5
        run_d(1'b1, 5'd5, 16'h1234, lat);
        run_d(1'b0, 5'd5, 16'h0000, lat);
        chk("wr_rd_5", bus.d_rdata, 16'h1234);
        chk("if_kept", bus.if_rdata, 16'hF400);

        // Operand change after grant
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 5'd1;
        step();
        bus.d_addr = 5'd2;
        lat = 0;
        while (!bus.d_ack && lat < 12) begin
            step();
            lat++;
        end
        bus.d_req = 1'b0;
        chk("op_hold", bus.d_rdata, 16'h0001);
        step();

        // Boundary addresses from both ports at once
        bus.if_req = 1'b1;
        bus.if_addr = 5'd31;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 5'd0;
        for (int i = 0; i < 12; i++) begin
            if (bus.if_ack) bus.if_req = 1'b0;
            if (bus.d_ack) bus.d_req = 1'b0;
            step();
        end
        chk("wrap_if31", bus.if_rdata, ref_mem[31]);
        chk("wrap_d0", bus.d_rdata, ref_mem[0]);

        // Randomized traffic from both requesters
        for (int k = 0; k < 600; k++) begin
            if (bus.if_ack) begin
                bus.if_req = 1'b0;
            end else if (!bus.if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.if_req = 1'b1;
                    bus.if_addr = raddr();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.if_addr = raddr();
            end
            if (bus.d_ack) begin
                bus.d_req = 1'b0;
            end else if (!bus.d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.d_req = 1'b1;
                    bus.d_we = 1'($urandom);
                    bus.d_addr = raddr();
                    bus.d_wdata = 16'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.d_we = 1'($urandom);
                bus.d_addr = raddr();
                bus.d_wdata = 16'($urandom);
            end
            step();
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Reset during the strobe of a write
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 5'd9;
        bus.d_wdata = 16'hBEEF;
        lat = 0;
        while (!bus.mem_wr && lat < 8) begin
            step();
            lat++;
        end
        chk("wr_seen", bus.mem_wr, 1);
        bus.d_req = 1'b0;
        rst = 1'b1;
        #1;
        rst_chk();
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        run_d(1'b1, 5'd9, 16'hBEEF, lat);
        chk("reissue_lat", lat, 3);
        run_d(1'b0, 5'd9, 16'h0000, lat);
        chk("reissue_rd", bus.d_rdata, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
